fetch_align: RTL and testbench
==============================

# fetch_align

Instruction fetch aligner between the instruction-memory fetch stream and decode. It accepts word-aligned 32-bit fetch words, splits them into 16-bit parcels, and reassembles 32-bit instructions, including those that straddle a word boundary. It emits one instruction per cycle, either 16-bit compressed or 32-bit, with its PC. It also discards stale fetch words after a branch or jump redirect.

## Interface
- RESET_PC, 32'h0000_0000: PC of the first instruction after reset; bit 0 must be 0.
- clk  input  1  sole clock; all state updates on the rising edge
- rst  input  1  reset, synchronous, active-high; one clock, no other clock domains
- redirect_valid  input  1  flush and restart at redirect_pc
- redirect_pc  input  32  new PC; halfword aligned, bit 0 ignored
- fetch_valid  input  1  fetch word present
- fetch_ready  output  1  aligner accepts the fetch word this cycle
- fetch_addr  input  32  byte address of fetch_data; bits [1:0] are always 0
- fetch_data  input  32  little-endian word; parcel 0 is [15:0], parcel 1 is [31:16]
- instr_valid  output  1  instruction available
- instr_ready  input  1  decode consumes the instruction
- instr_data  output  32  instruction; compressed instructions are zero-extended to {16'h0, parcel}
- instr_compressed  output  1  instr_data holds a 16-bit instruction
- instr_pc  output  32  PC of instr_data

## Operation
- Internal state:
  - 4-entry parcel queue, count 0..4
  - head_pc: PC of the oldest parcel
  - exp_addr: next word address to accept
  - skip_lo: flag to drop parcel 0 of the first word after a redirect
- Length decode of the head parcel:
  - [1:0] != 2'b11 means a 16-bit instruction.
  - [1:0] == 2'b11 means a 32-bit instruction.
  - 48-bit and longer encodings are not supported and are treated as 32-bit.
- instr_valid = !rst && ((count>=1 && head is compressed) || count>=2).
- On an output handshake, pop 1 parcel (compressed) or 2 parcels. head_pc advances by 2 or 4 and wraps modulo 2^32.
- fetch_ready = !rst && count<=2. It has no combinational dependence on instr_ready.
- Fetch handshake with fetch_addr != exp_addr: the word is consumed and dropped; no push.
- Fetch handshake with fetch_addr == exp_addr:
  - Push parcels 0 and 1, or parcel 1 only if skip_lo is set.
  - Clear skip_lo.
  - exp_addr += 4.
- A pop and a push in the same cycle are both applied: count_next = count − pop + push.
- redirect_valid has priority over everything in the same cycle:
  - count ← 0
  - head_pc ← {redirect_pc[31:1],1'b0}
  - exp_addr ← {redirect_pc[31:2],2'b00}
  - skip_lo ← redirect_pc[1]
  - A fetch word handshaken in that cycle is dropped.
  - An instruction handshaken in that cycle counts as consumed by decode; the aligner does not replay it.
- 32-bit instruction straddling words (head parcel is 32-bit, count==1): instr_valid stays low until the next matching word arrives.
- Reset: count=0, head_pc=RESET_PC, exp_addr={RESET_PC[31:2],2'b00}, skip_lo=RESET_PC[1], instr_valid=0, fetch_ready=0. Reset mid-stream discards all queued parcels.

## Timing
- Latency: a word accepted in cycle N makes instr_valid available in cycle N+1. Outputs are driven from queue registers only.
- Throughput is 1 instruction/cycle. Aligned 32-bit streams sustain one fetch word per cycle at count==2.
- While instr_valid && !instr_ready and no redirect: instr_data, instr_pc and instr_compressed hold stable.
- Fetch side is valid/ready; the upstream source must hold fetch_addr and fetch_data until the handshake.
- The first instruction after a redirect in cycle N is available in cycle N+2 at the earliest, given a matching word in N+1.

## Structure
- The 32-bit and 16-bit instruction unions (instr_type, cinstr_type) already live in riscv_pkg.
- Add to riscv_pkg:
  - function is_compressed(logic [15:0])
  - localparam PARCEL_W = 16
- One sub-module, fetch_parcel_q: 4×16-bit queue that does push-0/1/2, pop-0/1/2 and flush, exposing head[31:0] and count.
- The length decode, exp_addr/skip_lo filter and PC tracking stay in fetch_align.

## Test plan
- Reset with RESET_PC=0. Words @0 = 32'h0051_0093, @4 = 32'h0062_0113, instr_ready=1 -> two 32-bit instructions at pc 0 and 4 in consecutive cycles, instr_compressed=0, fetch_ready never drops.
- Word @0 = 32'h4505_4501 (two c.li) -> pc 0 emits 16'h4501 and pc 2 emits 16'h4505, compressed=1, instr_data=32'h0000_4501 then 32'h0000_4505.
- Straddle: @0 = {16'h0093, 16'h4501}, @4 = {16'h4505, 16'h0051} -> pc 0 compressed 16'h4501; pc 2 emits 32'h0051_0093 only after the @4 word arrives; pc 6 emits 16'h4505.
- Redirect to 32'h0000_0102 while the stale word @0 is in flight -> @0 is dropped; @0x100 = 32'h4505_4501 yields only pc 0x102 with data 16'h4505.
- Backpressure with instr_ready=0 for 5 cycles -> outputs stable, count saturates at 4, fetch_ready=0 once count==3. Assert rst mid-stream -> next cycle instr_valid=0, count=0, instr_pc=RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V instruction types plus the parcel helpers used by the fetch aligner.
package riscv_pkg;

    localparam int PARCEL_W = 16;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } r_fmt_t;

    typedef struct packed {
        logic [11:0] imm;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } i_fmt_t;

    typedef union packed {
        logic [31:0] raw;
        r_fmt_t      r;
        i_fmt_t      i;
    } instr_type;

    typedef struct packed {
        logic [2:0] funct3;
        logic       imm5;
        logic [4:0] rd;
        logic [4:0] imm;
        logic [1:0] op;
    } ci_fmt_t;

    typedef union packed {
        logic [15:0] raw;
        ci_fmt_t     ci;
    } cinstr_type;

    // Encodings of 48 bits and longer are not supported and fall into the 32-bit case.
    function automatic logic is_compressed(input logic [15:0] parcel);
        return parcel[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_parcel_q.sv
// Four-entry 16-bit parcel queue; entry 0 is always the oldest parcel, so the head
// instruction candidate is simply the two lowest entries.
module fetch_parcel_q
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic [1:0]            i_push_cnt,
    input  logic [2*PARCEL_W-1:0] i_push_data,
    input  logic [1:0]            i_pop_cnt,
    output logic [2*PARCEL_W-1:0] o_head,
    output logic [2:0]            o_count
);

    logic [PARCEL_W-1:0] r_q [4];
    logic [2:0]          r_count;

    logic [PARCEL_W-1:0] w_q_next [4];
    logic [2:0]          w_count_next;
    logic [2:0]          w_base;
    logic [1:0]          w_base_p1;

    // Shift out popped parcels first, then append pushed parcels behind the survivors.
    always_comb begin
        w_base       = r_count - {1'b0, i_pop_cnt};
        w_base_p1    = w_base[1:0] + 2'd1;
        w_count_next = w_base + {1'b0, i_push_cnt};
        w_q_next     = r_q;
        case (i_pop_cnt)
            2'd1:    w_q_next = '{r_q[1], r_q[2], r_q[3], r_q[3]};
            2'd2:    w_q_next = '{r_q[2], r_q[3], r_q[3], r_q[3]};
            default: w_q_next = r_q;
        endcase
        if (i_push_cnt != 2'd0) begin
            w_q_next[w_base[1:0]] = i_push_data[PARCEL_W-1:0];
        end
        if (i_push_cnt == 2'd2) begin
            w_q_next[w_base_p1] = i_push_data[2*PARCEL_W-1:PARCEL_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 3'd0;
            r_q     <= '{default: '0};
        end else if (i_flush) begin
            r_count <= 3'd0;
        end else begin
            r_count <= w_count_next;
            r_q     <= w_q_next;
        end
    end

    assign o_head  = {r_q[1], r_q[0]};
    assign o_count = r_count;

endmodule

// File: rtl/fetch_align.sv
// Fetch aligner: filters stale fetch words, splits them into parcels and hands
// decode one 16- or 32-bit instruction per cycle together with its PC.
module fetch_align
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] fetch_addr,
    input  logic [31:0] fetch_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic        instr_compressed,
    output logic [31:0] instr_pc
);

    logic [31:0] r_head_pc;
    logic [31:0] r_exp_addr;
    logic        r_skip_lo;

    logic [31:0] w_head;
    logic [2:0]  w_count;
    cinstr_type  w_head_parcel;
    instr_type   w_instr;
    logic        w_head_comp;
    logic        w_instr_fire;
    logic        w_fetch_fire;
    logic        w_accept;
    logic [1:0]  w_pop_cnt;
    logic [1:0]  w_push_cnt;
    logic [31:0] w_push_data;

    fetch_parcel_q u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (redirect_valid),
        .i_push_cnt  (w_push_cnt),
        .i_push_data (w_push_data),
        .i_pop_cnt   (w_pop_cnt),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign w_head_parcel = w_head[15:0];
    assign w_head_comp   = is_compressed(w_head_parcel.raw);

    assign instr_valid = !rst && ((w_count >= 3'd1 && w_head_comp) || w_count >= 3'd2);
    assign fetch_ready = !rst && (w_count <= 3'd2);

    assign w_instr_fire = instr_valid && instr_ready;
    assign w_fetch_fire = fetch_valid && fetch_ready;
    // Words at any other address are stale prefetch and are swallowed without a push.
    assign w_accept     = w_fetch_fire && !redirect_valid && (fetch_addr == r_exp_addr);

    always_comb begin
        w_pop_cnt   = 2'd0;
        w_push_cnt  = 2'd0;
        w_push_data = fetch_data;
        if (w_instr_fire && !redirect_valid) begin
            w_pop_cnt = w_head_comp ? 2'd1 : 2'd2;
        end
        if (w_accept) begin
            w_push_cnt = r_skip_lo ? 2'd1 : 2'd2;
        end
        if (r_skip_lo) begin
            w_push_data = {16'h0000, fetch_data[31:16]};
        end
    end

    always_comb begin
        w_instr.raw = w_head;
        if (w_head_comp) begin
            w_instr.raw = {16'h0000, w_head[15:0]};
        end
    end

    assign instr_data       = w_instr.raw;
    assign instr_compressed = w_head_comp;
    assign instr_pc         = r_head_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_pc  <= {RESET_PC[31:1], 1'b0};
            r_exp_addr <= {RESET_PC[31:2], 2'b00};
            r_skip_lo  <= RESET_PC[1];
        end else if (redirect_valid) begin
            r_head_pc  <= redirect_pc & ~32'h1;
            r_exp_addr <= redirect_pc & ~32'h3;
            r_skip_lo  <= redirect_pc[1];
        end else begin
            if (w_instr_fire) begin
                r_head_pc <= r_head_pc + (w_head_comp ? 32'd2 : 32'd4);
            end
            if (w_accept) begin
                r_exp_addr <= r_exp_addr + 32'd4;
                r_skip_lo  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_align.sv
// Directed bench for fetch_align: a per-cycle vector table plus hand-written
// sequences for reset recovery and redirect latency.
module tb_fetch_align;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic        instr_compressed;
    logic [31:0] instr_pc;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        rst;
        logic        redirV;
        logic [31:0] redirPc;
        logic        fetchV;
        logic [31:0] fetchAddr;
        logic [31:0] fetchData;
        logic        instrRdy;
        logic        expFr;
        logic        expIv;
        logic [31:0] expData;
        logic        expComp;
        logic [31:0] expPc;
    } vec_t;

    vec_t vecs[$];

    fetch_align #(.RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .fetch_valid      (fetch_valid),
        .fetch_ready      (fetch_ready),
        .fetch_addr       (fetch_addr),
        .fetch_data       (fetch_data),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr_data       (instr_data),
        .instr_compressed (instr_compressed),
        .instr_pc         (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rpc,
                                input logic fv, input logic [31:0] fa, input logic [31:0] fd,
                                input logic ir, input logic efr, input logic eiv,
                                input logic [31:0] ed, input logic ec, input logic [31:0] epc);
        vec_t v;
        v.rst = r;   v.redirV = rv;   v.redirPc = rpc;
        v.fetchV = fv; v.fetchAddr = fa; v.fetchData = fd;
        v.instrRdy = ir;
        v.expFr = efr; v.expIv = eiv; v.expData = ed; v.expComp = ec; v.expPc = epc;
        return v;
    endfunction

    // Shorthands: a plain fetch/idle cycle, and a redirect cycle.
    function automatic vec_t cyc(input logic fv, input logic [31:0] fa, input logic [31:0] fd,
                                 input logic ir, input logic efr, input logic eiv,
                                 input logic [31:0] ed, input logic ec, input logic [31:0] epc);
        return mk(1'b0, 1'b0, 32'h0, fv, fa, fd, ir, efr, eiv, ed, ec, epc);
    endfunction

    function automatic vec_t redir(input logic [31:0] rpc, input logic fv, input logic [31:0] fa,
                                   input logic [31:0] fd, input logic ir);
        return mk(1'b0, 1'b1, rpc, fv, fa, fd, ir, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    endfunction

    task automatic checkEq(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst            = v.rst;
        redirect_valid = v.redirV;
        redirect_pc    = v.redirPc;
        fetch_valid    = v.fetchV;
        fetch_addr     = v.fetchAddr;
        fetch_data     = v.fetchData;
        instr_ready    = v.instrRdy;
    endtask

    task automatic checkOutput(input int k, input vec_t v);
        checkEq($sformatf("vec%0d fetch_ready", k), {31'b0, fetch_ready}, {31'b0, v.expFr});
        checkEq($sformatf("vec%0d instr_valid", k), {31'b0, instr_valid}, {31'b0, v.expIv});
        if (v.expIv) begin
            checkEq($sformatf("vec%0d instr_data", k), instr_data, v.expData);
            checkEq($sformatf("vec%0d instr_compressed", k), {31'b0, instr_compressed}, {31'b0, v.expComp});
            checkEq($sformatf("vec%0d instr_pc", k), instr_pc, v.expPc);
        end
    endtask

    task automatic idleCycle(input logic rdy);
        @(negedge clk);
        applyStimulus(cyc(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
        #1;
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        fetch_valid = 1'b0; fetch_addr = '0; fetch_data = '0; instr_ready = 1'b0;

        // Two aligned 32-bit instructions back to back.
        vecs.push_back(cyc(1, 32'h0, 32'h0051_0093, 1, 1, 0, 32'h0, 0, 32'h0));
        vecs.push_back(cyc(1, 32'h4, 32'h0062_0113, 1, 1, 1, 32'h0051_0093, 0, 32'h0));
        vecs.push_back(cyc(0, 32'h0, 32'h0,         1, 1, 1, 32'h0062_0113, 0, 32'h4));
        vecs.push_back(cyc(0, 32'h0, 32'h0,         1, 1, 0, 32'h0, 0, 32'h0));
        // Two compressed instructions in one word.
        vecs.push_back(redir(32'h0, 0, 32'h0, 32'h0, 1));
        vecs.push_back(cyc(1, 32'h0, 32'h4505_4501, 1, 1, 0, 32'h0, 0, 32'h0));
        vecs.push_back(cyc(0, 32'h0, 32'h0,         1, 1, 1, 32'h0000_4501, 1, 32'h0));
        vecs.push_back(cyc(0, 32'h0, 32'h0,         1, 1, 1, 32'h0000_4505, 1, 32'h2));
        vecs.push_back(cyc(0, 32'h0, 32'h0,         1, 1, 0, 32'h0, 0, 32'h0));
        // 32-bit instruction straddling a word boundary; count reaches 3.
        vecs.push_back(redir(32'h0, 0, 32'h0, 32'h0, 1));
        vecs.push_back(cyc(1, 32'h0, 32'h0093_4501, 1, 1, 0, 32'h0, 0, 32'h0));
        vecs.push_back(cyc(0, 32'h0, 32'h0,         1, 1, 1, 32'h0000_4501, 1, 32'h0));
        vecs.push_back(cyc(0, 32'h0, 32'h0,         1, 1, 0, 32'h0, 0, 32'h0));
        vecs.push_back(cyc(1, 32'h4, 32'h4505_0051, 1, 1, 0, 32'h0, 0, 32'h0));
        vecs.push_back(cyc(0, 32'h0, 32'h0,         1, 0, 1, 32'h0051_0093, 0, 32'h2));
        vecs.push_back(cyc(0, 32'h0, 32'h0,         1, 1, 1, 32'h0000_4505, 1, 32'h6));
        vecs.push_back(cyc(0, 32'h0, 32'h0,         1, 1, 0, 32'h0, 0, 32'h0));
        // Redirect to an odd halfword with stale words in flight.
        vecs.push_back(redir(32'h102, 1, 32'h0, 32'h0051_0093, 1));
        vecs.push_back(cyc(1, 32'h0,   32'h0051_0093, 1, 1, 0, 32'h0, 0, 32'h0));
        vecs.push_back(cyc(1, 32'h100, 32'h4505_4501, 1, 1, 0, 32'h0, 0, 32'h0));
        vecs.push_back(cyc(0, 32'h0,   32'h0,         1, 1, 1, 32'h0000_4505, 1, 32'h102));
        vecs.push_back(cyc(0, 32'h0,   32'h0,         1, 1, 0, 32'h0, 0, 32'h0));
        // PC and expected address wrap at the top of the address space.
        vecs.push_back(redir(32'hFFFF_FFFC, 0, 32'h0, 32'h0, 1));
        vecs.push_back(cyc(1, 32'hFFFF_FFFC, 32'h0051_0093, 1, 1, 0, 32'h0, 0, 32'h0));
        vecs.push_back(cyc(1, 32'h0, 32'h4505_4501, 1, 1, 1, 32'h0051_0093, 0, 32'hFFFF_FFFC));
        vecs.push_back(cyc(0, 32'h0, 32'h0,         1, 1, 1, 32'h0000_4501, 1, 32'h0));
        vecs.push_back(cyc(0, 32'h0, 32'h0,         1, 1, 1, 32'h0000_4505, 1, 32'h2));
        vecs.push_back(cyc(0, 32'h0, 32'h0,         1, 1, 0, 32'h0, 0, 32'h0));
        // Backpressure: queue fills to 4, outputs hold, then drains.
        vecs.push_back(redir(32'h200, 0, 32'h0, 32'h0, 0));
        vecs.push_back(cyc(1, 32'h200, 32'h0051_0093, 0, 1, 0, 32'h0, 0, 32'h0));
        vecs.push_back(cyc(1, 32'h204, 32'h0062_0113, 0, 1, 1, 32'h0051_0093, 0, 32'h200));
        for (int i = 0; i < 3; i++) begin
            vecs.push_back(cyc(1, 32'h208, 32'h0073_0193, 0, 0, 1, 32'h0051_0093, 0, 32'h200));
        end
        vecs.push_back(cyc(1, 32'h208, 32'h0073_0193, 1, 0, 1, 32'h0051_0093, 0, 32'h200));
        vecs.push_back(cyc(1, 32'h208, 32'h0073_0193, 1, 1, 1, 32'h0062_0113, 0, 32'h204));
        // Synchronous reset mid-stream.
        vecs.push_back(mk(1, 0, 32'h0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h0, 0, 32'h0));

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            checkEq("reset instr_valid", {31'b0, instr_valid}, 32'h0);
            checkEq("reset fetch_ready", {31'b0, fetch_ready}, 32'h0);
        end

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            applyStimulus(vecs[k]);
            #1;
            checkOutput(k, vecs[k]);
        end

        // After the mid-stream reset the queue is empty and the PC is back at RESET_PC.
        idleCycle(1'b1);
        checkEq("post-reset instr_valid", {31'b0, instr_valid}, 32'h0);
        checkEq("post-reset fetch_ready", {31'b0, fetch_ready}, 32'h1);
        checkEq("post-reset instr_pc", instr_pc, 32'h0);
        @(negedge clk);
        applyStimulus(cyc(1, 32'h0, 32'h4505_4501, 1, 0, 0, 32'h0, 0, 32'h0));
        #1;
        checkEq("post-reset accept instr_valid", {31'b0, instr_valid}, 32'h0);
        idleCycle(1'b1);
        checkEq("post-reset first instr_valid", {31'b0, instr_valid}, 32'h1);
        checkEq("post-reset first instr_data", instr_data, 32'h0000_4501);
        checkEq("post-reset first instr_pc", instr_pc, 32'h0);

        // Redirect in the same cycle as a consumed instruction; no replay afterwards.
        @(negedge clk);
        applyStimulus(redir(32'h10, 0, 32'h0, 32'h0, 1));
        #1;
        checkEq("redir-cycle instr_data", instr_data, 32'h0000_4505);
        checkEq("redir-cycle instr_pc", instr_pc, 32'h2);
        @(negedge clk);
        applyStimulus(cyc(1, 32'h10, 32'h0051_0093, 1, 0, 0, 32'h0, 0, 32'h0));
        #1;
        checkEq("redir N+1 instr_valid", {31'b0, instr_valid}, 32'h0);
        idleCycle(1'b1);
        checkEq("redir N+2 instr_valid", {31'b0, instr_valid}, 32'h1);
        checkEq("redir N+2 instr_data", instr_data, 32'h0051_0093);
        checkEq("redir N+2 instr_pc", instr_pc, 32'h10);
        idleCycle(1'b1);
        checkEq("redir drained instr_valid", {31'b0, instr_valid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
